// File: rtl/binary_distributor_pkg.sv
// Shared definitions for the flit distributor: default widths, flit-type
// encodings and the steering FSM state type.
package binary_distributor_pkg;

    localparam int DFLT_FLIT_SIZE  = 32;
    localparam int DFLT_HEADER_LEN = 2;

    localparam logic [DFLT_HEADER_LEN-1:0] HEAD_FLIT   = 2'b10;
    localparam logic [DFLT_HEADER_LEN-1:0] BODY_FLIT   = 2'b00;
    localparam logic [DFLT_HEADER_LEN-1:0] TAIL_FLIT   = 2'b01;
    localparam logic [DFLT_HEADER_LEN-1:0] SINGLE_FLIT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } dist_state_e;

    // HEAD and SINGLE both open a new packet and carry a valid destination.
    function automatic logic is_pkt_start(input logic [DFLT_HEADER_LEN-1:0] t);
        return (t == HEAD_FLIT) || (t == SINGLE_FLIT);
    endfunction

endpackage

// File: rtl/binary_distributor_flit_out_reg.sv
// One-flit output register; accepts a write in the same cycle it drains so
// a steady stream passes at one flit per cycle.
module flit_out_reg
    import binary_distributor_pkg::*;
#(
    parameter int FLIT_SIZE = DFLT_FLIT_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_i,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 ready_o,
    input  logic                 avail_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 valid_o
);

    logic [FLIT_SIZE-1:0] data_q, data_d;
    logic                 valid_q, valid_d;

    assign ready_o = ~valid_q | avail_i;
    assign data_o  = data_q;
    assign valid_o = valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (wr_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (avail_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/binary_distributor.sv
// 1-to-2 wormhole packet distributor: the header destination picks an output
// and the choice is held until the tail so packets never interleave.
module binary_distributor
    import binary_distributor_pkg::*;
#(
    parameter int          FLIT_SIZE   = DFLT_FLIT_SIZE,
    parameter int          HEADER_LEN  = DFLT_HEADER_LEN,
    parameter int          DEST_POS    = 29,
    parameter int          DEST_LEN    = 4,
    parameter int unsigned SPLIT_POINT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLIT_SIZE-1:0] in_i,
    input  logic                 in_valid_i,
    output logic                 in_avail_o,
    output logic [FLIT_SIZE-1:0] out0_o,
    output logic                 out0_valid_o,
    input  logic                 out0_avail_i,
    output logic [FLIT_SIZE-1:0] out1_o,
    output logic                 out1_valid_o,
    input  logic                 out1_avail_i,
    output logic                 err_pulse_o
);

    logic [FLIT_SIZE-1:0]  slot_q, slot_d;
    logic                  slot_valid_q, slot_valid_d;
    dist_state_e           state_q, state_d;
    logic                  err_q, err_d;

    logic [HEADER_LEN-1:0] typ;
    logic [DEST_LEN-1:0]   dest;
    logic                  route1, pkt_start, locked, discard, abort, port1;
    logic                  out0_ready, out1_ready, wr_ok, slot_moves, wr0, wr1, in_take;

    always_comb begin
        typ       = slot_q[FLIT_SIZE-1 -: HEADER_LEN];
        dest      = slot_q[DEST_POS -: DEST_LEN];
        route1    = 32'(dest) >= SPLIT_POINT;
        pkt_start = is_pkt_start(typ);
        locked    = (state_q != ST_IDLE);
        // Orphan BODY/TAIL with no open packet is dropped without waiting on any output.
        discard   = ~locked & ~pkt_start;
        abort     = locked & pkt_start;
        port1     = pkt_start ? route1 : (state_q == ST_LOCK1);
        wr_ok     = port1 ? out1_ready : out0_ready;
        slot_moves = slot_valid_q & (discard | wr_ok);
        wr0       = slot_moves & ~discard & ~port1;
        wr1       = slot_moves & ~discard &  port1;
        err_d     = slot_moves & (discard | abort);
    end

    always_comb begin
        state_d = state_q;
        if (slot_moves) begin
            if (discard) begin
                state_d = ST_IDLE;
            end else if (typ == HEAD_FLIT) begin
                state_d = port1 ? ST_LOCK1 : ST_LOCK0;
            end else if (typ != BODY_FLIT) begin
                state_d = ST_IDLE;
            end
        end
    end

    assign in_avail_o = ~rst & (~slot_valid_q | slot_moves);
    assign in_take    = in_valid_i & in_avail_o;

    always_comb begin
        slot_d       = slot_q;
        slot_valid_d = slot_valid_q;
        if (in_take) begin
            slot_d       = in_i;
            slot_valid_d = 1'b1;
        end else if (slot_moves) begin
            slot_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q       <= '0;
            slot_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
            err_q        <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            slot_valid_q <= slot_valid_d;
            state_q      <= state_d;
            err_q        <= err_d;
        end
    end

    assign err_pulse_o = err_q;

    flit_out_reg #(.FLIT_SIZE(FLIT_SIZE)) u_out0 (
        .clk     (clk),
        .rst     (rst),
        .wr_i    (wr0),
        .data_i  (slot_q),
        .ready_o (out0_ready),
        .avail_i (out0_avail_i),
        .data_o  (out0_o),
        .valid_o (out0_valid_o)
    );

    flit_out_reg #(.FLIT_SIZE(FLIT_SIZE)) u_out1 (
        .clk     (clk),
        .rst     (rst),
        .wr_i    (wr1),
        .data_i  (slot_q),
        .ready_o (out1_ready),
        .avail_i (out1_avail_i),
        .data_o  (out1_o),
        .valid_o (out1_valid_o)
    );

endmodule

// File: tb/tb_binary_distributor.sv
// Directed bench for binary_distributor: routing, locking, back-pressure,
// protocol errors and mid-packet reset.
module tb_binary_distributor;
    import binary_distributor_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_d;
    logic        in_valid, in_avail;
    logic [31:0] out0, out1;
    logic        out0_valid, out0_avail, out1_valid, out1_avail, err_pulse;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    binary_distributor dut (
        .clk          (clk),
        .rst          (rst),
        .in_i         (in_d),
        .in_valid_i   (in_valid),
        .in_avail_o   (in_avail),
        .out0_o       (out0),
        .out0_valid_o (out0_valid),
        .out0_avail_i (out0_avail),
        .out1_o       (out1),
        .out1_valid_o (out1_valid),
        .out1_avail_i (out1_avail),
        .err_pulse_o  (err_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] d, input logic [25:0] p);
        return {t, d, p};
    endfunction

    logic [31:0] f[5];
    logic [31:0] rx[$];
    logic [31:0] h1, b1, h2, s1, h12, tl, s8;
    int          idx;
    logic        acc;

    initial begin
        rst = 1'b1; in_d = '0; in_valid = 1'b0; out0_avail = 1'b1; out1_avail = 1'b1;
        tick;
        chk("avail_in_reset", 32'(in_avail), 32'd0);
        tick;
        rst = 1'b0;
        chk("rst_out0_valid", 32'(out0_valid), 32'd0);
        chk("rst_out1_valid", 32'(out1_valid), 32'd0);
        chk("rst_out0_data", out0, 32'd0);
        chk("rst_err", 32'(err_pulse), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

        // SINGLE dest=3 -> out0 two cycles after acceptance
        in_d = mk(SINGLE_FLIT, 4'd3, 26'h0000AA); in_valid = 1'b1;
        #1;
        chk("avail_after_reset", 32'(in_avail), 32'd1);
        tick;
        in_valid = 1'b0;
        chk("single_lat1_out0_valid", 32'(out0_valid), 32'd0);
        tick;
        chk("single_out0_valid", 32'(out0_valid), 32'd1);
        chk("single_out0_data", out0, mk(SINGLE_FLIT, 4'd3, 26'h0000AA));
        chk("single_out1_valid", 32'(out1_valid), 32'd0);
        chk("single_state", 32'(dut.state_q), 32'(ST_IDLE));
        tick;
        chk("single_drained", 32'(out0_valid), 32'd0);

        // HEAD/BODY/BODY/TAIL dest=12 streamed back-to-back to out1
        f[0] = mk(HEAD_FLIT, 4'd12, 26'h11); f[1] = mk(BODY_FLIT, 4'd0, 26'h22);
        f[2] = mk(BODY_FLIT, 4'd5, 26'h33);  f[3] = mk(TAIL_FLIT, 4'd1, 26'h44);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin in_d = f[i]; in_valid = 1'b1; end else in_valid = 1'b0;
            #1;
            if (i < 4) chk($sformatf("stream_avail_%0d", i), 32'(in_avail), 32'd1);
            tick;
            if (i >= 1) begin
                chk($sformatf("stream_out1_valid_%0d", i), 32'(out1_valid), 32'd1);
                chk($sformatf("stream_out1_data_%0d", i), out1, f[i-1]);
                chk($sformatf("stream_out0_quiet_%0d", i), 32'(out0_valid), 32'd0);
            end
        end
        chk("stream_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        tick;

        // Packet to out0 with out0 blocked for 5 cycles
        f[0] = mk(HEAD_FLIT, 4'd2, 26'h101); f[1] = mk(BODY_FLIT, 4'd0, 26'h102);
        f[2] = mk(BODY_FLIT, 4'd0, 26'h103); f[3] = mk(BODY_FLIT, 4'd0, 26'h104);
        f[4] = mk(TAIL_FLIT, 4'd0, 26'h105);
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            out0_avail = (c >= 5);
            if (idx < 5) begin in_d = f[idx]; in_valid = 1'b1; end else in_valid = 1'b0;
            #1;
            if (c == 2) chk("stall_avail_c2", 32'(in_avail), 32'd0);
            if (c == 4) chk("stall_avail_c4", 32'(in_avail), 32'd0);
            if (c == 5) chk("stall_release_avail", 32'(in_avail), 32'd1);
            acc = in_valid && in_avail;
            if (out0_valid && out0_avail) rx.push_back(out0);
            tick;
            if (acc) idx++;
        end
        chk("stall_rx_count", 32'(rx.size()), 32'd5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("stall_rx_%0d", k), (k < rx.size()) ? rx[k] : 32'hDEADBEEF, f[k]);
        chk("stall_state_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // Orphan BODY in IDLE
        out0_avail = 1'b1; out1_avail = 1'b1;
        in_d = mk(BODY_FLIT, 4'd0, 26'h7); in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("orphan_err_pre", 32'(err_pulse), 32'd0);
        tick;
        chk("orphan_err", 32'(err_pulse), 32'd1);
        chk("orphan_no_out0", 32'(out0_valid), 32'd0);
        chk("orphan_no_out1", 32'(out1_valid), 32'd0);
        tick;
        chk("orphan_err_one_cycle", 32'(err_pulse), 32'd0);

        // HEAD d2, BODY, then HEAD d9 without a tail
        h1 = mk(HEAD_FLIT, 4'd2, 26'h201); b1 = mk(BODY_FLIT, 4'd0, 26'h202);
        h2 = mk(HEAD_FLIT, 4'd9, 26'h203);
        in_d = h1; in_valid = 1'b1; tick;
        in_d = b1; tick;
        in_d = h2; tick;
        in_valid = 1'b0;
        chk("abort_err_pre", 32'(err_pulse), 32'd0);
        chk("abort_state_lock0", 32'(dut.state_q), 32'(ST_LOCK0));
        tick;
        chk("abort_err", 32'(err_pulse), 32'd1);
        chk("abort_out1_valid", 32'(out1_valid), 32'd1);
        chk("abort_out1_data", out1, h2);
        chk("abort_state_lock1", 32'(dut.state_q), 32'(ST_LOCK1));

        // Build up a locked, fully blocked pipeline then reset it
        tl = mk(TAIL_FLIT, 4'd0, 26'h301); s1 = mk(SINGLE_FLIT, 4'd1, 26'h302);
        h12 = mk(HEAD_FLIT, 4'd12, 26'h303);
        in_d = tl; in_valid = 1'b1; tick;
        out0_avail = 1'b0; out1_avail = 1'b0; in_d = s1; tick;
        out1_avail = 1'b1; in_d = h12; tick;
        out1_avail = 1'b0; in_d = b1; tick;
        in_valid = 1'b0;
        #1;
        chk("full_out0_valid", 32'(out0_valid), 32'd1);
        chk("full_out1_valid", 32'(out1_valid), 32'd1);
        chk("full_state_lock1", 32'(dut.state_q), 32'(ST_LOCK1));
        chk("full_in_avail", 32'(in_avail), 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_in_avail", 32'(in_avail), 32'd0);
        tick;
        chk("midrst_out0_valid", 32'(out0_valid), 32'd0);
        chk("midrst_out1_valid", 32'(out1_valid), 32'd0);
        chk("midrst_out1_data", out1, 32'd0);
        chk("midrst_err", 32'(err_pulse), 32'd0);
        chk("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
        rst = 1'b0; out0_avail = 1'b1; out1_avail = 1'b1;
        s8 = mk(SINGLE_FLIT, 4'd8, 26'h401);
        in_d = s8; in_valid = 1'b1;
        #1;
        chk("postrst_in_avail", 32'(in_avail), 32'd1);
        tick;
        in_valid = 1'b0;
        tick;
        chk("split_out1_valid", 32'(out1_valid), 32'd1);
        chk("split_out1_data", out1, s8);
        chk("split_out0_quiet", 32'(out0_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
